// File: rtl/param_seq_detector.sv
// Programmable serial bit-pattern detector with saturating match counter
// and seven-segment readout of the low hex digit of the count.
module param_seq_detector #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int LW      = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               x_valid,
   input  logic               x,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] pattern_in,
   input  logic [LW-1:0]      pat_len_in,
   input  logic               overlap_in,
   input  logic               clr_count,
   output logic               match,
   output logic [CNT_W-1:0]   match_count,
   output logic [LW-1:0]      fill,
   output logic [7:0]         seg
);

   localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LW-1:0]      fill_q, fill_d;
   logic               match_q, match_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LW-1:0]      len_q, len_d;
   logic               ovl_q, ovl_d;
   logic [6:0]         seg_q, seg_d;

   logic [MAX_LEN-1:0] hist_next;
   logic [LW-1:0]      fill_next;
   logic [MAX_LEN-1:0] len_mask;
   logic               hit;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Candidate history, fill and pattern compare for the current sample
   always_comb begin
      hist_next = {hist_q[MAX_LEN-2:0], x};
      fill_next = (fill_q == MAX_LEN_L) ? fill_q : fill_q + 1'b1;
      len_mask  = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < 32'(len_q));
      end
      hit = x_valid && !cfg_load && (len_q != '0) && (fill_next >= len_q) &&
            ((hist_next & len_mask) == (pat_q & len_mask));
   end

   // Next-state for config, history, match pulse, counter and display
   always_comb begin
      hist_d  = hist_q;
      fill_d  = fill_q;
      match_d = 1'b0;
      cnt_d   = cnt_q;
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;

      if (cfg_load) begin
         pat_d  = pattern_in;
         len_d  = (pat_len_in > MAX_LEN_L) ? MAX_LEN_L : pat_len_in;
         ovl_d  = overlap_in;
         hist_d = '0;
         fill_d = '0;
      end else if (x_valid) begin
         hist_d  = hist_next;
         // non-overlap restarts the fill so the next match needs fresh bits
         fill_d  = (hit && !ovl_q) ? '0 : fill_next;
         match_d = hit;
      end

      if (clr_count) begin
         cnt_d = '0;
      end else if (hit && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end

      // decoding the next count keeps the digit aligned with match_count
      seg_d = hex_to_seg(cnt_d[3:0]);
   end

   // State registers, asynchronous active-high reset
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
         cnt_q   <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         seg_q   <= 7'h3F;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         cnt_q   <= cnt_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         seg_q   <= seg_d;
      end
   end

   assign match       = match_q;
   assign match_count = cnt_q;
   assign fill        = fill_q;
   assign seg         = {match_q, seg_q};

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed bench for param_seq_detector: default instance plus a CNT_W=4
// instance sharing the same stimulus for the saturation case.
module tb_param_seq_detector;

   localparam int MAX_LEN = 8;
   localparam int LW      = $clog2(MAX_LEN + 1);

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               x_valid = 1'b0;
   logic               x = 1'b0;
   logic               cfg_load = 1'b0;
   logic [MAX_LEN-1:0] pattern_in = '0;
   logic [LW-1:0]      pat_len_in = '0;
   logic               overlap_in = 1'b0;
   logic               clr_count = 1'b0;

   logic               match, match4;
   logic [7:0]         match_count;
   logic [3:0]         match_count4;
   logic [LW-1:0]      fill, fill4;
   logic [7:0]         seg, seg4;

   int errors = 0;
   int checks = 0;

   param_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x(x), .cfg_load(cfg_load),
      .pattern_in(pattern_in), .pat_len_in(pat_len_in), .overlap_in(overlap_in),
      .clr_count(clr_count), .match(match), .match_count(match_count),
      .fill(fill), .seg(seg)
   );

   param_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x(x), .cfg_load(cfg_load),
      .pattern_in(pattern_in), .pat_len_in(pat_len_in), .overlap_in(overlap_in),
      .clr_count(clr_count), .match(match4), .match_count(match_count4),
      .fill(fill4), .seg(seg4)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic b, input logic em, input string tag);
      x = b;
      x_valid = 1'b1;
      tick();
      x_valid = 1'b0;
      check(tag, 32'(match), 32'(em));
   endtask

   task automatic idle();
      tick();
      check("idle_match", 32'(match), 0);
   endtask

   task automatic cfg(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l, input logic ov);
      pattern_in = p;
      pat_len_in = l;
      overlap_in = ov;
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      check("cfg_match", 32'(match), 0);
      check("cfg_fill", 32'(fill), 0);
   endtask

   task automatic clear_counts();
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      check("clr_cnt", 32'(match_count), 0);
      check("clr_cnt4", 32'(match_count4), 0);
   endtask

   initial begin
      logic [19:0] rnd_bits;
      logic [7:0]  long_pat;

      // reset state
      #12;
      check("rst_match", 32'(match), 0);
      check("rst_cnt", 32'(match_count), 0);
      check("rst_fill", 32'(fill), 0);
      check("rst_seg", 32'(seg), 32'h3F);
      @(negedge clk);
      rst_n = 1'b0;
      tick();

      // "100" overlapping
      cfg(8'b100, 4'd3, 1'b1);
      send(1, 0, "p100_s1");
      send(0, 0, "p100_s2");
      send(0, 1, "p100_s3");
      check("p100_seg1", 32'(seg), 32'h86);
      send(1, 0, "p100_s4");
      send(0, 0, "p100_s5");
      send(0, 1, "p100_s6");
      check("p100_seg2", 32'(seg), 32'hDB);
      idle();
      check("p100_cnt", 32'(match_count), 2);
      check("p100_seg", 32'(seg), 32'h5B);
      clear_counts();

      // "101" overlapping then non-overlapping
      cfg(8'b101, 4'd3, 1'b1);
      send(1, 0, "ov1_s1");
      send(0, 0, "ov1_s2");
      send(1, 1, "ov1_s3");
      send(0, 0, "ov1_s4");
      send(1, 1, "ov1_s5");
      check("ov1_cnt", 32'(match_count), 2);
      cfg(8'b101, 4'd3, 1'b0);
      send(1, 0, "ov0_s1");
      send(0, 0, "ov0_s2");
      send(1, 1, "ov0_s3");
      check("ov0_fill_hit", 32'(fill), 0);
      send(0, 0, "ov0_s4");
      send(1, 0, "ov0_s5");
      check("ov0_fill", 32'(fill), 2);
      check("ov0_cnt", 32'(match_count), 3);

      // x_valid gap with "11"
      cfg(8'b11, 4'd2, 1'b1);
      send(1, 0, "gap_s1");
      x = 1'b0;
      idle();
      send(1, 1, "gap_s2");
      check("gap_cnt", 32'(match_count), 4);
      // pattern inputs change without cfg_load: old "11" still active
      pattern_in = '0;
      pat_len_in = 4'd1;
      send(1, 1, "nocfg_s");
      check("nocfg_cnt", 32'(match_count), 5);
      clear_counts();

      // saturation with "1", len 1
      cfg(8'b1, 4'd1, 1'b1);
      for (int i = 0; i < 17; i++) send(1, 1, "sat_s");
      check("sat_cnt8", 32'(match_count), 17);
      check("sat_cnt4", 32'(match_count4), 15);
      check("sat_seg4_pulse", 32'(seg4), 32'hF1);
      idle();
      check("sat_seg4", 32'(seg4), 32'h71);
      check("sat_seg8", 32'(seg), 32'h06);
      clr_count = 1'b1;
      send(1, 1, "clrhit_match");
      clr_count = 1'b0;
      check("clrhit_cnt", 32'(match_count), 0);
      check("clrhit_cnt4", 32'(match_count4), 0);
      check("clrhit_seg", 32'(seg), 32'hBF);

      // disabled detector, len 0 (pattern 0 would otherwise match zeros)
      cfg(8'b0, 4'd0, 1'b1);
      rnd_bits = 20'hA5F30;
      for (int i = 19; i >= 0; i--) send(rnd_bits[i], 0, "len0_s");
      check("len0_cnt", 32'(match_count), 0);

      // clamped length with a simultaneous sample that must be dropped
      long_pat = 8'b1011_0110;
      x = 1'b1;
      x_valid = 1'b1;
      cfg(long_pat, 4'd11, 1'b1);
      x_valid = 1'b0;
      for (int i = 7; i >= 1; i--) send(long_pat[i], 0, "clamp_s");
      check("clamp_fill7", 32'(fill), 7);
      send(long_pat[0], 1, "clamp_hit");
      check("clamp_fill8", 32'(fill), 8);
      send(1, 0, "clamp_after");
      check("clamp_fill_sat", 32'(fill), 8);
      check("clamp_cnt", 32'(match_count), 1);

      // reset mid-stream
      cfg(8'b100, 4'd3, 1'b1);
      send(1, 0, "rstm_s1");
      send(0, 0, "rstm_s2");
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      check("rstm_fill_async", 32'(fill), 0);
      check("rstm_cnt_async", 32'(match_count), 0);
      @(negedge clk);
      rst_n = 1'b0;
      send(0, 0, "rstm_s3");
      idle();
      check("rstm_cnt", 32'(match_count), 0);
      check("rstm_seg", 32'(seg), 32'h3F);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
